pu_intr_dispatch: RTL and testbench

// - Routes interrupt requests from SRCCOUNT device sources to the PUCOUNT PUs of a multipu.
// - Drives each PU's intrqst_i and watches its intrdy_o.
// - Selects the next pending source round-robin and a ready PU round-robin.
// - Holds the request until the PU takes it, then acknowledges the source.
// - Sits between the interrupt-source fabric and the multipu intrqst_i/intrdy_o buses.

---
 rtl/pu_intr_dispatch.sv | 125 ++++++++++++
 tb/tb_pu_intr_dispatch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_intr_dispatch.sv
// Interrupt dispatcher: offers pending device interrupts, round-robin by source and by ready PU,
// holds the offer until the PU takes it, times out, or is withdrawn, and then pulses the source ack.
module pu_intr_dispatch #(
  parameter int PUCOUNT  = 2,
  parameter int SRCCOUNT = 4,
  parameter int TIMEOUT  = 255,
  localparam int SRCIDW  = (SRCCOUNT > 1) ? $clog2(SRCCOUNT) : 1,
  localparam int PUIDW   = (PUCOUNT > 1) ? $clog2(PUCOUNT) : 1,
  localparam int TMOW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SRCCOUNT-1:0] src_rqst_i,
  output logic [SRCCOUNT-1:0] src_ack_o,
  output logic [SRCIDW-1:0]   srcid_o,
  output logic [PUCOUNT-1:0]  intrqst_o,
  input  logic [PUCOUNT-1:0]  intrdy_i
);

  localparam logic [SRCIDW-1:0] SRC_LAST = SRCIDW'(SRCCOUNT - 1);
  localparam logic [PUIDW-1:0]  PU_LAST  = PUIDW'(PUCOUNT - 1);
  localparam logic [TMOW-1:0]   TMO_LAST = TMOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RQST, ACK} state_t;

  state_t            state;
  logic [SRCIDW-1:0] srcptr;
  logic [PUIDW-1:0]  puptr;
  logic [PUIDW-1:0]  pu_lat;
  logic [TMOW-1:0]   tmo;

  logic [SRCIDW-1:0] s_sel, s_idx;
  logic [PUIDW-1:0]  p_sel, p_idx;
  logic              s_found, p_found;

  function automatic logic [SRCIDW-1:0] src_next(input logic [SRCIDW-1:0] v);
    return (v == SRC_LAST) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [PUIDW-1:0] pu_next(input logic [PUIDW-1:0] v);
    return (v == PU_LAST) ? '0 : v + 1'b1;
  endfunction

  // Scan from the pointer upward with explicit wrap; the first hit wins.
  always_comb begin
    s_found = 1'b0;
    s_sel   = '0;
    s_idx   = srcptr;
    for (int i = 0; i < SRCCOUNT; i++) begin
      if (!s_found && src_rqst_i[s_idx]) begin
        s_found = 1'b1;
        s_sel   = s_idx;
      end
      s_idx = src_next(s_idx);
    end
  end

  always_comb begin
    p_found = 1'b0;
    p_sel   = '0;
    p_idx   = puptr;
    for (int i = 0; i < PUCOUNT; i++) begin
      if (!p_found && intrdy_i[p_idx]) begin
        p_found = 1'b1;
        p_sel   = p_idx;
      end
      p_idx = pu_next(p_idx);
    end
  end

  // srcid_o doubles as the latched source index for the whole offer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      intrqst_o <= '0;
      src_ack_o <= '0;
      srcid_o   <= '0;
      srcptr    <= '0;
      puptr     <= '0;
      pu_lat    <= '0;
      tmo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          src_ack_o <= '0;
          if (s_found && p_found) begin
            intrqst_o <= PUCOUNT'(1) << p_sel;
            srcid_o   <= s_sel;
            pu_lat    <= p_sel;
            tmo       <= '0;
            state     <= RQST;
          end
        end
        RQST: begin
          if (!intrdy_i[pu_lat]) begin
            intrqst_o <= '0;
            src_ack_o <= SRCCOUNT'(1) << srcid_o;
            srcptr    <= src_next(srcid_o);
            puptr     <= pu_next(pu_lat);
            state     <= ACK;
          end else if (!src_rqst_i[srcid_o]) begin
            intrqst_o <= '0;
            state     <= IDLE;
          end else if (tmo == TMO_LAST) begin
            intrqst_o <= '0;
            puptr     <= pu_next(pu_lat);
            state     <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ACK: begin
          src_ack_o <= '0;
          state     <= IDLE;
        end
        default: begin
          intrqst_o <= '0;
          src_ack_o <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_intr_dispatch.sv
// Bench for pu_intr_dispatch: directed scenarios with literal expectations, then randomized
// source/PU agents checked every cycle against a transaction-level reference model.
module tb_pu_intr_dispatch;
  localparam int P = 2;
  localparam int S = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S-1:0] rqst;
  logic [P-1:0] rdy;
  logic [S-1:0] ack;
  logic [1:0]   srcid;
  logic [P-1:0] irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pu_intr_dispatch #(.PUCOUNT(P), .SRCCOUNT(S), .TIMEOUT(T)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_rqst_i(rqst),
    .src_ack_o (ack),
    .srcid_o   (srcid),
    .intrqst_o (irq),
    .intrdy_i  (rdy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding offer (pu, src, age) and a pending ack.
  bit m_off, m_ack;
  int m_pu, m_src, m_age, m_ack_src, m_sptr, m_pptr;
  int n_acc = 0, n_wd = 0, n_to = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_off = 0; m_ack = 0; m_pu = 0; m_src = 0; m_age = 0; m_sptr = 0; m_pptr = 0;
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_off) begin
      if (!rdy[m_pu]) begin
        m_off = 0; m_ack = 1; m_ack_src = m_src;
        m_sptr = (m_src + 1) % S; m_pptr = (m_pu + 1) % P; n_acc++;
      end else if (!rqst[m_src]) begin
        m_off = 0; n_wd++;
      end else if (m_age == T - 1) begin
        m_off = 0; m_pptr = (m_pu + 1) % P; n_to++;
      end else begin
        m_age++;
      end
    end else if (rqst != 0 && rdy != 0) begin
      bit fs, fp;
      fs = 0; fp = 0;
      for (int k = 0; k < S; k++)
        if (!fs && rqst[(m_sptr + k) % S]) begin fs = 1; m_src = (m_sptr + k) % S; end
      for (int k = 0; k < P; k++)
        if (!fp && rdy[(m_pptr + k) % P]) begin fp = 1; m_pu = (m_pptr + k) % P; end
      m_off = 1; m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_irq", irq, m_off ? (32'd1 << m_pu) : 32'd0);
      chk("model_ack", ack, m_ack ? (32'd1 << m_ack_src) : 32'd0);
      if (m_off) chk("model_srcid", srcid, m_src);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, bad, p, s;
    bit sawack;
    rqst = '0; rdy = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_irq", irq, 0);
    chk("rst_ack", ack, 0);
    chk("rst_srcid", srcid, 0);

    // Basic offer and accept
    rqst = 4'b0100; rdy = 2'b11;
    tick();
    chk("t2_irq", irq, 2'b01);
    chk("t2_srcid", srcid, 2);
    tick(); tick();
    rdy = 2'b10;
    tick();
    chk("t2_ack", ack, 4'b0100);
    chk("t2_irq_drop", irq, 0);
    rqst = '0; rdy = 2'b11;
    tick();

    // Withdraw and accept in the same cycle: accept wins
    rqst = 4'b0010;
    tick();
    chk("t5_irq", irq, 2'b10);
    rqst = '0; rdy = 2'b01;
    tick();
    chk("t5_ack", ack, 4'b0010);
    rdy = 2'b11;
    tick();
    // Pure withdraw: no ack
    rqst = 4'b0010;
    tick();
    chk("t5w_irq", irq, 2'b01);
    chk("t5w_srcid", srcid, 1);
    rqst = '0;
    tick();
    chk("t5w_irq_drop", irq, 0);
    chk("t5w_noack", ack, 0);

    // Timeout with PU0 never taking the offer
    rqst = 4'b0001;
    tick();
    n = 0; sawack = 0;
    for (int i = 0; i < 20 && irq == 2'b01; i++) begin
      n++;
      if (ack != 0) sawack = 1;
      tick();
    end
    chk("t4_len", n, T);
    chk("t4_noack", {31'd0, sawack || (ack != 0)}, 0);
    tick();
    chk("t4_next_irq", irq, 2'b10);
    chk("t4_next_srcid", srcid, 0);
    rdy = 2'b01;
    tick();
    chk("t4_ack", ack, 4'b0001);
    rqst = '0; rdy = 2'b11;
    tick();

    // No ready PU
    rdy = 2'b00; rqst = 4'b0001; bad = 0;
    repeat (50) begin
      tick();
      if (irq != 0) bad++;
    end
    chk("t6_hold", bad, 0);
    rdy = 2'b10;
    tick();
    chk("t6_irq", irq, 2'b10);
    rdy = 2'b00;
    tick();
    chk("t6_ack", ack, 4'b0001);
    rqst = '0; rdy = 2'b11;
    tick();

    // Asynchronous reset mid-offer
    rqst = 4'b1111;
    tick();
    chk("t1_pre", {31'd0, irq != 0}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_irq", irq, 0);
    chk("t1_ack", ack, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_first_irq", irq, 2'b01);
    chk("t1_first_srcid", srcid, 0);

    // Round-robin with all sources pending
    for (int d = 0; d < 5; d++) begin
      for (int i = 0; i < 10 && irq == 0; i++) tick();
      p = irq[1] ? 1 : 0;
      s = srcid;
      if (d < 4) chk("t3_pu", p, d % 2);
      chk("t3_src", s, d % 4);
      rdy[p] = 1'b0;
      tick();
      chk("t3_ack", ack, 32'd1 << (d % 4));
      rqst[s] = 1'b0; rdy = 2'b11;
      tick();
      rqst[s] = 1'b1;
    end

    // Randomized agents
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < S; i++) begin
        if (ack[i]) rqst[i] = 1'b0;
        else if (irq != 0 && srcid == i && rqst[i] && $urandom_range(0, 19) == 0) rqst[i] = 1'b0;
        else if (!rqst[i] && $urandom_range(0, 3) == 0) rqst[i] = 1'b1;
      end
      for (int j = 0; j < P; j++) begin
        if (irq[j]) rdy[j] = ($urandom_range(0, 3) != 0);
        else if (rdy[j]) rdy[j] = ($urandom_range(0, 9) != 0);
        else rdy[j] = ($urandom_range(0, 2) == 0);
      end
    end

    chk("cov_accept", {31'd0, n_acc > 0}, 1);
    chk("cov_withdraw", {31'd0, n_wd > 0}, 1);
    chk("cov_timeout", {31'd0, n_to > 0}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
